multicycle_ctrl: RTL and testbench

//  Multi-cycle main controller; consumes IR and W_IR_valid from the fetch stage, drives its write_ir/write_pc/pc_s.

---
 rtl/multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main controller for a multi-cycle ARM-subset datapath. It runs as a Moore
//   FSM on the rising clock edge. The fetch stage samples the strobes on the
//   following falling edge. The controller sequences the following instruction
//   classes:
//     - data-processing (DP) and compare instructions
//     - LDR and STR, with a configurable memory latency
//     - B, BL and BX
//     - the undefined-instruction class
//
//   Parameters
//     MEM_LAT : number of data-memory access cycles per LDR/STR (must be >= 1)
//     CNT_W   : width of the performance counters
//
//   Optional feature macro: MULTICYCLE_PERF_EN
//     defined     : cyc_cnt and ret_cnt are live counters
//     not defined : no counter flops; both counter outputs are tied to 0
//
//   Ports
//     clk          in   system clock (rising edge)
//     rst_n        in   asynchronous active-low reset
//     IR           in   latched instruction from the fetch stage
//     W_IR_valid   in   condition-pass flag from the fetch stage
//     write_ir     out  IR load strobe
//     write_pc     out  PC update strobe
//     pc_s         out  PC source: 00 = PC+4, 01 = branch target, 10 = register
//     alu_op       out  ALU opcode
//     alu_src_imm  out  ALU B operand is the immediate
//     nzcv_we      out  update the NZCV flags
//     rf_we        out  register-file write enable
//     rf_wsel      out  RF write data: 0 = ALU result, 1 = memory data
//     lr_we        out  write the PC into R14 (BL)
//     mem_re       out  data-memory read
//     mem_we       out  data-memory write
//     instr_done   out  pulse on the last state of each instruction
//     undef        out  pulse on an undefined instruction
//     state        out  current state code (debug)
//     cyc_cnt      out  cycle counter
//     ret_cnt      out  retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IR,
    input  logic             W_IR_valid,
    output logic             write_ir,
    output logic             write_pc,
    output logic [1:0]       pc_s,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             nzcv_we,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             lr_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             instr_done,
    output logic             undef,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    // The counter only has to hold MEM_LAT-1.
    localparam int MC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB     = 4'd3,
        S_MADDR  = 4'd4,
        S_MRD    = 4'd5,
        S_MWR    = 4'd6,
        S_WBLD   = 4'd7,
        S_BR     = 4'd8,
        S_BX     = 4'd9
    } state_e;

    state_e            state_q, state_d;
    logic [MC_W-1:0]   mem_cnt_q, mem_cnt_d;

    logic              is_bx;
    logic [3:0]        dp_op;
    logic              is_cmp;
    logic              unused_ir;

    assign is_bx     = (IR[27:4] == 24'h12FFF1);
    assign dp_op     = IR[24:21];
    // TST/TEQ/CMP/CMN (opcodes 8..B) only set the flags and have no write-back.
    assign is_cmp    = (dp_op[3:2] == 2'b10);
    // The condition field is evaluated in the fetch stage.
    assign unused_ir = ^{IR[31:28], IR[3:0]};

    // -------------------------------------------------------------------------
    // State register. An asynchronous reset forces FETCH immediately, so the
    // memory strobes and rf_we drop without waiting for a clock edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            mem_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and Moore outputs (decoded from state, IR and counter).
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_cnt_d   = mem_cnt_q;
        write_ir    = 1'b0;
        write_pc    = 1'b0;
        pc_s        = 2'b00;
        alu_op      = 4'h0;
        alu_src_imm = 1'b0;
        nzcv_we     = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 1'b0;
        lr_we       = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        instr_done  = 1'b0;
        undef       = 1'b0;

        case (state_q)
            S_FETCH: begin
                // The PC advances even when the condition fails.
                // A skipped instruction therefore costs exactly one cycle.
                write_ir = 1'b1;
                write_pc = 1'b1;
                pc_s     = 2'b00;
                state_d  = W_IR_valid ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (is_bx) begin
                    state_d = S_BX;
                end else begin
                    case (IR[27:26])
                        2'b00:   state_d = S_EXEC;
                        2'b01:   state_d = S_MADDR;
                        2'b10:   state_d = S_BR;
                        default: begin
                            undef      = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                alu_op      = dp_op;
                alu_src_imm = IR[25];
                nzcv_we     = IR[20];
                if (is_cmp) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                rf_wsel    = 1'b0;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MADDR: begin
                // IR[23] (U bit) selects whether the offset is added or subtracted.
                alu_src_imm = 1'b1;
                alu_op      = IR[23] ? 4'h4 : 4'h2;
                mem_cnt_d   = MC_W'(MEM_LAT - 1);
                state_d     = IR[20] ? S_MRD : S_MWR;
            end
            S_MRD: begin
                mem_re = 1'b1;
                if (mem_cnt_q == '0) begin
                    state_d = S_WBLD;
                end else begin
                    mem_cnt_d = mem_cnt_q - MC_W'(1);
                end
            end
            S_MWR: begin
                mem_we = 1'b1;
                if (mem_cnt_q == '0) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    mem_cnt_d = mem_cnt_q - MC_W'(1);
                end
            end
            S_WBLD: begin
                rf_we      = 1'b1;
                rf_wsel    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BR: begin
                write_pc   = 1'b1;
                pc_s       = 2'b01;
                lr_we      = IR[24];
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BX: begin
                write_pc   = 1'b1;
                pc_s       = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unused codes 10..15 recover to FETCH without asserting any strobe.
                state_d = S_FETCH;
            end
        endcase
    end

    assign state = state_q;

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] ret_cnt_q;

    // Both counters wrap naturally modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
            if (instr_done) begin
                ret_cnt_q <= ret_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int LAT   = 3;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      IR;
    logic             W_IR_valid;
    logic             write_ir, write_pc;
    logic [1:0]       pc_s;
    logic [3:0]       alu_op;
    logic             alu_src_imm, nzcv_we, rf_we, rf_wsel, lr_we;
    logic             mem_re, mem_we, instr_done, undef;
    logic [3:0]       state;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt;

    multicycle_ctrl #(.MEM_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .IR(IR), .W_IR_valid(W_IR_valid),
        .write_ir(write_ir), .write_pc(write_pc), .pc_s(pc_s), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .nzcv_we(nzcv_we), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .lr_we(lr_we), .mem_re(mem_re), .mem_we(mem_we), .instr_done(instr_done),
        .undef(undef), .state(state), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint model_cyc = 0;
    longint model_ret = 0;
    logic [20:0] exp_q[$];

    // Packed output vector:
    // {state, write_ir, write_pc, pc_s, alu_op, alu_src_imm, nzcv_we,
    //  rf_we, rf_wsel, lr_we, mem_re, mem_we, instr_done, undef}
    function automatic logic [20:0] ev(logic [3:0] st, logic wir, logic wpc, logic [1:0] pcs,
                                       logic [3:0] op, logic imm, logic nz, logic rfwe,
                                       logic wsel, logic lr, logic re, logic we,
                                       logic done, logic und);
        return {st, wir, wpc, pcs, op, imm, nz, rfwe, wsel, lr, re, we, done, und};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {state, write_ir, write_pc, pc_s, alu_op, alu_src_imm, nzcv_we,
                rf_we, rf_wsel, lr_we, mem_re, mem_we, instr_done, undef};
    endfunction

    // Reference timeline: the expected output vector for every cycle of one
    // instruction, derived from the instruction-class rules.
    function automatic void build(input logic [31:0] ir, input logic v);
        logic [3:0] op;
        logic       cmp;
        exp_q.delete();
        exp_q.push_back(ev(4'd0, 1, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!v) return;
        if (ir[27:4] == 24'h12FFF1) begin
            exp_q.push_back(ev(4'd1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(ev(4'd9, 0, 1, 2'b10, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            return;
        end
        case (ir[27:26])
            2'b00: begin
                op  = ir[24:21];
                cmp = (op >= 4'h8) && (op <= 4'hB);
                exp_q.push_back(ev(4'd1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(ev(4'd2, 0, 0, 2'b00, op, ir[25], ir[20], 0, 0, 0, 0, 0, cmp, 0));
                if (!cmp)
                    exp_q.push_back(ev(4'd3, 0, 0, 2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
            end
            2'b01: begin
                exp_q.push_back(ev(4'd1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(ev(4'd4, 0, 0, 2'b00, ir[23] ? 4'h4 : 4'h2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                for (int k = 0; k < LAT; k++) begin
                    if (ir[20])
                        exp_q.push_back(ev(4'd5, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
                    else
                        exp_q.push_back(ev(4'd6, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 1, (k == LAT - 1), 0));
                end
                if (ir[20])
                    exp_q.push_back(ev(4'd7, 0, 0, 2'b00, 4'h0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
            end
            2'b10: begin
                exp_q.push_back(ev(4'd1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(ev(4'd8, 0, 1, 2'b01, 4'h0, 0, 0, 0, 0, ir[24], 0, 0, 1, 0));
            end
            default: begin
                exp_q.push_back(ev(4'd1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
            end
        endcase
    endfunction

    task automatic check_counters(input string tag);
        logic [CNT_W-1:0] ec, er;
`ifdef MULTICYCLE_PERF_EN
        ec = CNT_W'(model_cyc);
        er = CNT_W'(model_ret);
`else
        ec = '0;
        er = '0;
`endif
        checks++;
        if (cyc_cnt !== ec) begin
            errors++;
            $display("FAIL cyc_cnt %s: got %0d exp %0d", tag, cyc_cnt, ec);
        end
        checks++;
        if (ret_cnt !== er) begin
            errors++;
            $display("FAIL ret_cnt %s: got %0d exp %0d", tag, ret_cnt, er);
        end
    endtask

    // Run one instruction. The task is entered at a negedge with the DUT in
    // FETCH, and it returns in the same condition.
    task automatic run_instr(input logic [31:0] ir, input logic v, input int exp_lat, input string tag);
        int          n;
        logic [20:0] e;
        IR = ir;
        W_IR_valid = v;
        build(ir, v);
        #1;
        n = 0;
        do begin
            e = (n < exp_q.size()) ? exp_q[n] : 21'h1FFFFF;
            checks++;
            if (dut_vec() !== e) begin
                errors++;
                $display("FAIL outs %s ir=%h cyc=%0d: got %h exp %h", tag, ir, n, dut_vec(), e);
            end
            check_counters(tag);
            @(posedge clk);
            model_cyc++;
            if (e[1] && n < exp_q.size()) model_ret++;
            @(negedge clk);
            #1;
            n++;
        end while (state != 4'd0 && n < 40);
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL latency %s ir=%h: got %0d exp %0d", tag, ir, n, exp_lat);
        end
        $display("txn %s ir=%h valid=%0b cycles=%0d", tag, ir, v, n);
    endtask

    typedef struct {
        logic [31:0] ir;
        logic        valid;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] r;
        logic        v;

        tbl[0]  = '{32'hE0912003, 1'b1, 4,       "ADDS"};
        tbl[1]  = '{32'hE3510000, 1'b1, 3,       "CMPimm"};
        tbl[2]  = '{32'hE5910004, 1'b1, 4 + LAT, "LDR"};
        tbl[3]  = '{32'hE5810004, 1'b1, 3 + LAT, "STR"};
        tbl[4]  = '{32'hE5110004, 1'b1, 4 + LAT, "LDRsub"};
        tbl[5]  = '{32'hEB000010, 1'b1, 3,       "BL"};
        tbl[6]  = '{32'hEA000010, 1'b1, 3,       "B"};
        tbl[7]  = '{32'hE12FFF11, 1'b1, 3,       "BX"};
        tbl[8]  = '{32'hE0912003, 1'b0, 1,       "skip1"};
        tbl[9]  = '{32'hE3A01005, 1'b0, 1,       "skip2"};
        tbl[10] = '{32'hEC000000, 1'b1, 2,       "UNDEF"};
        tbl[11] = '{32'hE1100001, 1'b1, 3,       "TST"};

        rst_n = 1'b0;
        IR = 32'h0;
        W_IR_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dut_vec() !== ev(4'd0, 1, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_outs: got %h exp %h", dut_vec(),
                     ev(4'd0, 1, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        check_counters("reset");
        $display("txn reset state=%0d", state);

        @(negedge clk);
        rst_n = 1'b1;
        model_cyc = 0;
        model_ret = 0;

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].ir, tbl[i].valid, tbl[i].lat, tbl[i].name);
        end

        // Reset asserted in the middle of the MRD state of an LDR.
        IR = 32'hE5910004;
        W_IR_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!(mem_re === 1'b1 && state === 4'd5)) begin
            errors++;
            $display("FAIL mid_mrd: got mem_re=%b state=%0d exp mem_re=1 state=5", mem_re, state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!(mem_re === 1'b0 && state === 4'd0 && rf_we === 1'b0)) begin
            errors++;
            $display("FAIL async_abort: got mem_re=%b state=%0d rf_we=%b exp 0/0/0", mem_re, state, rf_we);
        end
        model_cyc = 0;
        model_ret = 0;
        check_counters("abort");
        $display("txn reset_mid_mrd state=%0d mem_re=%0b", state, mem_re);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised instruction stream.
        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            if ($urandom_range(0, 9) == 0) r[27:4] = 24'h12FFF1;
            v = ($urandom_range(0, 4) != 0);
            build(r, v);
            run_instr(r, v, exp_q.size(), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
